// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding, line idle level
// and the parity helper used by both directions.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_t;

   localparam logic LINE_IDLE      = 1'b1;
   localparam int   MAX_DATA_WIDTH = 32;

   // Callers zero-extend their word to MAX_DATA_WIDTH; extra zeros do not change the XOR.
   function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                        input logic                      odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Pop-side handshake between the transmit FIFO and the UART transmitter.
interface uart_tx_if #(
   parameter int DATA_WIDTH = 8
);

   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_read_data;
   logic                  fifo_read_enable;

   modport master (
      input  fifo_empty,
      input  fifo_read_data,
      output fifo_read_enable
   );

   modport slave (
      output fifo_empty,
      output fifo_read_data,
      input  fifo_read_enable
   );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period divider: free-running 0..CLKS_PER_BIT-1 counter with a one-cycle tick
// on each wrap; restart holds it at zero so the next bit starts on a clean boundary.
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int              CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (restart || count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = !restart && (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops one word from the transmit FIFO and sends start, data
// (LSB first), optional parity and 1 or 2 stop bits on a registered line.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic      clk,
   input  logic      reset,
   uart_tx_if.master fifo,
   output logic      tx,
   output logic      busy,
   output logic      tx_done
);

   localparam int             BCW       = $clog2(DATA_WIDTH + 1);
   localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_WIDTH - 1);
   localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

   uart_state_t              state;
   logic [DATA_WIDTH-1:0]    shift_reg;
   logic [BCW-1:0]           bit_cnt;
   logic                     parity_bit;
   logic                     read_enable;
   logic                     restart;
   logic                     tick;
   logic [MAX_DATA_WIDTH-1:0] load_word;

   // Holding the divider in restart until START makes the start bit exactly one period long.
   assign restart   = (state == ST_IDLE) || (state == ST_FETCH) || (state == ST_LOAD);
   assign load_word = MAX_DATA_WIDTH'(fifo.fifo_read_data);

   assign fifo.fifo_read_enable = read_enable;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .reset  (reset),
      .restart(restart),
      .tick   (tick)
   );

   // tx, busy and tx_done are registered from the current state, so the line
   // trails the state register by one cycle; read_enable is set on the transition.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         shift_reg   <= '0;
         bit_cnt     <= '0;
         parity_bit  <= 1'b0;
         read_enable <= 1'b0;
         tx          <= LINE_IDLE;
         busy        <= 1'b0;
         tx_done     <= 1'b0;
      end else begin
         read_enable <= 1'b0;
         tx_done     <= 1'b0;
         busy        <= !((state == ST_IDLE) && fifo.fifo_empty);

         case (state)
            ST_IDLE: begin
               tx <= LINE_IDLE;
               if (!fifo.fifo_empty) begin
                  state       <= ST_FETCH;
                  read_enable <= 1'b1;
               end
            end

            ST_FETCH: begin
               tx    <= LINE_IDLE;
               state <= ST_LOAD;
            end

            ST_LOAD: begin
               tx         <= LINE_IDLE;
               shift_reg  <= fifo.fifo_read_data;
               parity_bit <= calc_parity(load_word, PARITY_ODD != 0);
               bit_cnt    <= '0;
               state      <= ST_START;
            end

            ST_START: begin
               tx <= 1'b0;
               if (tick) begin
                  state <= ST_DATA;
               end
            end

            ST_DATA: begin
               tx <= shift_reg[0];
               if (tick) begin
                  shift_reg <= shift_reg >> 1;
                  if (bit_cnt == LAST_DATA) begin
                     bit_cnt <= '0;
                     state   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end

            ST_PARITY: begin
               tx <= parity_bit;
               if (tick) begin
                  state <= ST_STOP;
               end
            end

            // bit_cnt is reused here to count stop bits.
            ST_STOP: begin
               tx <= LINE_IDLE;
               if (tick) begin
                  if (bit_cnt == LAST_STOP) begin
                     bit_cnt <= '0;
                     tx_done <= 1'b1;
                     if (fifo.fifo_empty) begin
                        state <= ST_IDLE;
                     end else begin
                        state       <= ST_FETCH;
                        read_enable <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end

            default: begin
               tx    <= LINE_IDLE;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (8N1, even parity, odd parity, two
// stop bits) at CLKS_PER_BIT=4, each fed by a small FIFO model.
module tb_uart_tx;

   localparam int CPB = 4;

   typedef logic [7:0] byte_q_t[$];

   logic       clk;
   logic       reset;
   logic [3:0] tx_w;
   logic [3:0] busy_w;
   logic [3:0] done_w;
   logic [3:0] rd_w;
   logic [3:0] empty_v;
   logic [7:0] data_v [4];

   byte_q_t    fifo_q [4];
   int         rd_cnt [4];
   int         done_cnt [4];
   int         busy_low [4];
   int         tests_run;
   int         tests_failed;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      uart_tx_if #(.DATA_WIDTH(8)) fif ();

      assign fif.fifo_empty     = empty_v[g];
      assign fif.fifo_read_data = data_v[g];
      assign rd_w[g]            = fif.fifo_read_enable;

      uart_tx #(
         .DATA_WIDTH  (8),
         .CLKS_PER_BIT(CPB),
         .PARITY_EN   ((g == 1 || g == 2) ? 1 : 0),
         .PARITY_ODD  ((g == 2) ? 1 : 0),
         .STOP_BITS   ((g == 3) ? 2 : 1)
      ) dut (
         .clk    (clk),
         .reset  (reset),
         .fifo   (fif),
         .tx     (tx_w[g]),
         .busy   (busy_w[g]),
         .tx_done(done_w[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO model and event counters; pops land mid-cycle so data is stable at the capture edge.
   always @(negedge clk) begin
      for (int g = 0; g < 4; g++) begin
         if (rd_w[g]) begin
            rd_cnt[g]++;
            if (fifo_q[g].size() > 0) data_v[g] = fifo_q[g].pop_front();
         end
         empty_v[g] = (fifo_q[g].size() == 0);
         if (done_w[g]) done_cnt[g]++;
         if (!busy_w[g]) busy_low[g]++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
      tests_run++;
      if (got !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
      end
   endtask

   task automatic applyStimulus(input int g, input logic [7:0] word);
      @(posedge clk);
      #1;
      fifo_q[g].push_back(word);
      empty_v[g] = 1'b0;
   endtask

   task automatic wait_start(input int g, input string tag, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (tx_w[g] !== 1'b0 && cycles < 200);
      checkOutput({tag, " start"}, 32'(tx_w[g]), 32'd0);
   endtask

   // Called at the first sample of the start bit; samples every cycle of every bit.
   task automatic get_frame(input int g, input int nbits, output logic [15:0] bits,
                            output int bad, output logic [1:0] last_flags);
      bits = '0;
      bad  = 0;
      for (int k = 0; k < nbits; k++) begin
         for (int j = 0; j < CPB; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (j == 0) bits[k] = tx_w[g];
            else if (tx_w[g] !== bits[k]) bad++;
         end
      end
      last_flags = {busy_w[g], done_w[g]};
   endtask

   task automatic send_and_check(input int g, input logic [7:0] word, input int nbits,
                                 input logic [15:0] expected, input string tag);
      int         lat;
      int         bad;
      logic [15:0] bits;
      logic [1:0]  flags;
      applyStimulus(g, word);
      wait_start(g, tag, lat);
      get_frame(g, nbits, bits, bad, flags);
      checkOutput({tag, " frame"}, 32'(bits), 32'(expected));
      checkOutput({tag, " width"}, 32'(bad), 32'd0);
      checkOutput({tag, " last busy/done"}, 32'(flags), 32'd3);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int          lat;
      int          bad;
      int          hi;
      int          gap;
      logic [15:0] bits;
      logic [1:0]  flags;

      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      empty_v      = 4'hF;
      for (int g = 0; g < 4; g++) begin
         data_v[g]   = 8'h00;
         rd_cnt[g]   = 0;
         done_cnt[g] = 0;
         busy_low[g] = 0;
      end

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset tx", 32'(tx_w[0]), 32'd1);
      checkOutput("reset busy", 32'(busy_w[0]), 32'd0);
      checkOutput("reset tx_done", 32'(done_w[0]), 32'd0);
      checkOutput("reset read_enable", 32'(rd_w[0]), 32'd0);
      reset = 1'b1;

      hi = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx_w[0] === 1'b1) hi++;
      end
      #1;
      checkOutput("empty tx high cycles", 32'(hi), 32'd100);
      checkOutput("empty read_enable count", 32'(rd_cnt[0]), 32'd0);

      applyStimulus(0, 8'h55);
      wait_start(0, "single", lat);
      checkOutput("single latency", 32'(lat), 32'd5);
      get_frame(0, 10, bits, bad, flags);
      checkOutput("single frame 0x55", 32'(bits), 32'h2AA);
      checkOutput("single width", 32'(bad), 32'd0);
      checkOutput("single last busy/done", 32'(flags), 32'd3);
      @(negedge clk);
      checkOutput("single idle tx", 32'(tx_w[0]), 32'd1);
      checkOutput("single busy fall", 32'(busy_w[0]), 32'd0);
      #1;
      checkOutput("single done count", 32'(done_cnt[0]), 32'd1);
      checkOutput("single pop count", 32'(rd_cnt[0]), 32'd1);

      repeat (5) @(negedge clk);
      #1;
      rd_cnt[0] = 0;
      applyStimulus(0, 8'hA3);
      applyStimulus(0, 8'h3C);
      wait_start(0, "b2b first", lat);
      #1;
      busy_low[0] = 0;
      get_frame(0, 10, bits, bad, flags);
      checkOutput("b2b frame 0xA3", 32'(bits), 32'h346);
      checkOutput("b2b width 1", 32'(bad), 32'd0);
      gap = 0;
      do begin
         @(negedge clk);
         if (tx_w[0] === 1'b1) gap++;
      end while (tx_w[0] === 1'b1 && gap < 50);
      checkOutput("b2b idle gap", 32'(gap), 32'd2);
      get_frame(0, 10, bits, bad, flags);
      checkOutput("b2b frame 0x3C", 32'(bits), 32'h278);
      checkOutput("b2b width 2", 32'(bad), 32'd0);
      #1;
      checkOutput("b2b busy drops", 32'(busy_low[0]), 32'd0);
      checkOutput("b2b pop count", 32'(rd_cnt[0]), 32'd2);
      checkOutput("b2b fifo empty", 32'(empty_v[0]), 32'd1);
      repeat (4) @(negedge clk);

      send_and_check(1, 8'h07, 11, 16'h060E, "even 0x07");
      send_and_check(1, 8'h00, 11, 16'h0400, "even 0x00");
      send_and_check(2, 8'h07, 11, 16'h040E, "odd 0x07");
      send_and_check(3, 8'hFF, 11, 16'h07FE, "two stop 0xFF");

      applyStimulus(0, 8'hF0);
      wait_start(0, "reset frame", lat);
      repeat (4 * CPB) @(negedge clk);
      checkOutput("pre-reset data bit 3", 32'(tx_w[0]), 32'd0);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("async reset tx", 32'(tx_w[0]), 32'd1);
      checkOutput("async reset busy", 32'(busy_w[0]), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      send_and_check(0, 8'hC3, 10, 16'h0386, "after reset 0xC3");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART datapath, downstream of the transmit `sync_fifo`. It pops one word at a time from the FIFO whenever the FIFO is non-empty and serializes it onto `tx`. The frame is a start bit, DATA_WIDTH data bits LSB first, an optional parity bit and 1 or 2 stop bits, with the bit period fixed by a clock-divider parameter. `tx` idles high.

## Interface
- `DATA_WIDTH`, 8: word width; must match the FIFO.
- `CLKS_PER_BIT`, 16: clk cycles per serial bit; minimum 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

Ports:
- `clk` input 1: single clock; all logic is on its rising edge.
- `reset` input 1: reset is asynchronous and active-low.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_read_data` input DATA_WIDTH: FIFO registered read data, valid in the cycle after `fifo_read_enable`.
- `fifo_read_enable` output 1: pop request, registered, high for exactly one cycle per word.
- `tx` output 1: serial line, registered.
- `busy` output 1: high from the pop until the last stop bit completes.
- `tx_done` output 1: one-cycle pulse in the final cycle of the last stop bit.

## Operation
- **Reset (asynchronous, while `reset`=0):** `tx`=1, `fifo_read_enable`=0, `busy`=0, `tx_done`=0. State returns to IDLE; the bit counter, baud counter and shift register clear. Any frame in flight is abandoned and its word is lost.
- **States:** IDLE → FETCH → LOAD → START → DATA → [PARITY] → STOP → IDLE or FETCH.
- **IDLE:** `tx`=1. If `fifo_empty`=0, go to FETCH.
- **FETCH:** one cycle with `fifo_read_enable`=1; `busy`=1 from here on. Go to LOAD.
- **LOAD:**
  - One cycle; capture `fifo_read_data` into the shift register.
  - Compute parity: the XOR of the data, inverted when `PARITY_ODD`=1.
  - Go to START.
- **START:** `tx`=0 for CLKS_PER_BIT cycles.
- **DATA:** shift out bit 0 first, each bit held for CLKS_PER_BIT cycles, DATA_WIDTH bits in total.
- **PARITY:** present only when `PARITY_EN`=1; `tx`=parity bit for CLKS_PER_BIT cycles.
- **STOP:** `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles; `tx_done` pulses in the last cycle.
  - If `fifo_empty`=0 in that cycle, go to FETCH; `busy` stays high.
  - Otherwise go to IDLE; `busy`=0.
- **Counters:**
  - The baud counter is $clog2(CLKS_PER_BIT) bits wide, counts 0..CLKS_PER_BIT-1 and wraps, producing one bit tick per wrap.
  - The bit counter is $clog2(DATA_WIDTH+1) bits wide.
  - The baud counter restarts at 0 on entry to START.
- **FIFO usage:**
  - A pop is issued only when `fifo_empty`=0 is sampled, so the FIFO is never read while empty.
  - `fifo_empty` changing mid-frame has no effect.

## Timing
- `fifo_empty` sampled low in IDLE at edge 0 gives:
  - `fifo_read_enable` high in the cycle after edge 0;
  - data captured at edge 2;
  - `tx` falls at edge 3.
- Frame length = (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles.
- Back-to-back words leave exactly 2 extra idle-high cycles (FETCH and LOAD) between the last stop bit and the next start bit.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `uart_pkg`:
  - state enum (`ST_IDLE`, `ST_FETCH`, `ST_LOAD`, `ST_START`, `ST_DATA`, `ST_PARITY`, `ST_STOP`);
  - `LINE_IDLE`=1'b1;
  - a parity-compute function, reused by `uart_rx`.
- Sub-module `uart_baud_gen`: parameter CLKS_PER_BIT; inputs `clk`, `reset`, `restart`; output one-cycle `tick`. Shared with `uart_rx`.
- Top level: the FSM, shift register and bit counter.

## Test plan
- **Single word:** CLKS_PER_BIT=4, 8N1, push 0x55.
  - `tx` shows 0, then 1,0,1,0,1,0,1,0, then 1, each bit 4 cycles wide; 40 cycles in total.
  - `fifo_read_enable` is high for exactly 1 cycle.
  - `tx_done` pulses once; `busy` falls the cycle after it.
- **Parity:** PARITY_EN=1.
  - 0x07 with even parity gives parity bit 1.
  - 0x07 with PARITY_ODD=1 gives parity bit 0.
  - 0x00 with even parity gives parity bit 0.
- **Back-to-back:** push 0xA3 then 0x3C.
  - Two frames, with 2 extra cycles of `tx`=1 between the stop bit and the second start bit.
  - `busy` never drops; the FIFO becomes empty.
- **Two stop bits:** STOP_BITS=2, 0xFF → stop interval is 8 cycles; frame is 44 cycles.
- **Reset mid-frame:** assert `reset` low during DATA bit 3.
  - `tx`=1 and `busy`=0 immediately, without waiting for a clock edge.
  - After release, the next FIFO word transmits cleanly.
- **Empty FIFO:** hold `fifo_empty`=1 for 100 cycles → `fifo_read_enable` never asserts and `tx` stays 1.
